// File: rtl/uart_hex_rx.sv
// uart_hex_rx: UART receiver (8N1, LSB first, idle high) feeding an ASCII-hex
// command parser. Each pair of hex digits from the host becomes one byte.
//
// Ports:
//   clk        - system clock, single domain
//   rst        - synchronous reset, active-high
//   fpga_rx    - asynchronous serial input, idle high
//   rx_char    - last correctly framed character (valid with char_valid)
//   char_valid - one-cycle pulse per correctly framed character
//   data       - assembled byte, high nibble first; holds until next byte
//   data_valid - one-cycle pulse when data updates
//   frame_err  - one-cycle pulse when the stop bit samples low
//   hex_err    - one-cycle pulse for a character that is neither hex nor separator
module uart_hex_rx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned CTR_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fpga_rx,
  output logic [7:0] rx_char,
  output logic       char_valid,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       hex_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam logic [CTR_W-1:0] HALF_M1 = CTR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CTR_W-1:0] FULL_M1 = CTR_W'(CLKS_PER_BIT - 1);
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  // Receiver state
  logic             rx_meta_q, rx_meta_d;
  logic             rxs_q, rxs_d;
  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       rx_char_q, rx_char_d;
  logic             char_valid_q, char_valid_d;
  logic             frame_err_q, frame_err_d;

  // Parser state
  logic             pending_q, pending_d;
  logic [3:0]       high_q, high_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             hex_err_q, hex_err_d;

  logic [4:0]       dec;        // {is_hex, nibble}
  logic             is_sep;

  // Low nibble of the ASCII code already equals the digit for '0'-'9'; for
  // 'A'-'F' / 'a'-'f' the low nibble is 1..6, so adding 9 yields 10..15.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  always_comb begin
    rx_meta_d    = fpga_rx;
    rxs_d        = rx_meta_q;
    state_d      = state_q;
    ctr_d        = ctr_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    rx_char_d    = rx_char_q;
    char_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          ctr_d   = '0;
        end
      end
      S_START: begin
        if (ctr_q == HALF_M1) begin
          if (rxs_q) begin
            state_d = S_IDLE;      // glitch, not a real start bit
          end else begin
            state_d   = S_DATA;
            ctr_d     = '0;
            bit_idx_d = '0;
          end
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      S_DATA: begin
        if (ctr_q == FULL_M1) begin
          shreg_d[bit_idx_q] = rxs_q;
          ctr_d              = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      S_STOP: begin
        if (ctr_q == FULL_M1) begin
          ctr_d = '0;
          if (rxs_q) begin
            char_valid_d = 1'b1;
            rx_char_d    = shreg_q;
            state_d      = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end else begin
          ctr_d = ctr_q + CTR_ONE;
        end
      end
      S_WAIT_IDLE: begin
        // A held break reports once; only a return to idle re-arms the receiver.
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pending_d    = pending_q;
    high_d       = high_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    hex_err_d    = 1'b0;
    dec          = hex_decode(rx_char_q);
    is_sep       = (rx_char_q == 8'h0D) || (rx_char_q == 8'h0A) || (rx_char_q == 8'h20);

    if (char_valid_q) begin
      if (dec[4]) begin
        if (pending_q) begin
          data_d       = {high_q, dec[3:0]};
          data_valid_d = 1'b1;
          pending_d    = 1'b0;
        end else begin
          high_d    = dec[3:0];
          pending_d = 1'b1;
        end
      end else if (is_sep) begin
        pending_d = 1'b0;
      end else begin
        hex_err_d = 1'b1;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= S_IDLE;
      ctr_q        <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      rx_char_q    <= '0;
      char_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      pending_q    <= 1'b0;
      high_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      hex_err_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rxs_q        <= rxs_d;
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      rx_char_q    <= rx_char_d;
      char_valid_q <= char_valid_d;
      frame_err_q  <= frame_err_d;
      pending_q    <= pending_d;
      high_q       <= high_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      hex_err_q    <= hex_err_d;
    end
  end

  assign rx_char    = rx_char_q;
  assign char_valid = char_valid_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign hex_err    = hex_err_q;

endmodule

// File: tb/tb_uart_hex_rx.sv
// Testbench for uart_hex_rx: directed scenarios plus random character traffic,
// checked against an event-queue model of the receiver and hex parser.
module tb_uart_hex_rx;

  localparam int unsigned CPB = 16;

  localparam int EV_CHAR = 0;
  localparam int EV_DATA = 1;
  localparam int EV_HEX  = 2;
  localparam int EV_FRM  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fpga_rx = 1'b1;
  logic [7:0] rx_char;
  logic       char_valid;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       hex_err;

  uart_hex_rx #(
    .CLKS_PER_BIT(CPB),
    .CTR_W       (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fpga_rx   (fpga_rx),
    .rx_char   (rx_char),
    .char_valid(char_valid),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .hex_err   (hex_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;

  // Parser model state (owned by the stimulus process)
  bit         m_pending = 1'b0;
  logic [3:0] m_high    = '0;

  // Output model state (owned by the compare process)
  logic [7:0] exp_data = '0;
  logic       prev_cv  = 1'b0;
  logic       rst_seen = 1'b1;

  always @(posedge clk) rst_seen <= rst;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, req);
    end
  endtask

  // Consume the next expected event and compare it with the observed pulse.
  task automatic take(input string name, input int kind, input logic [7:0] act,
                      output logic [7:0] ev_val);
    ev_t e;
    n_vec++;
    ev_val = act;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got unexpected pulse (val %02h), expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      ev_val = e.val;
      if (e.kind != kind || e.val !== act) begin
        n_fail++;
        $display("FAIL %s: got kind %0d val %02h, expected kind %0d val %02h",
                 name, kind, act, e.kind, e.val);
      end
    end
  endtask

  // Hex value by table lookup after case folding; -1 when not a hex digit.
  function automatic int hexval(input logic [7:0] c);
    string      hx;
    logic [7:0] lc;
    hx = "0123456789abcdef";
    lc = c;
    if (c >= 8'h41 && c <= 8'h5A) lc = c + 8'd32;
    for (int i = 0; i < 16; i++) begin
      if (hx[i] == lc) return i;
    end
    return -1;
  endfunction

  task automatic push_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic model_char(input logic [7:0] c);
    int         v;
    logic [3:0] nv;
    push_ev(EV_CHAR, c);
    v = hexval(c);
    if (v >= 0) begin
      nv = 4'(v);
      if (m_pending) begin
        push_ev(EV_DATA, {m_high, nv});
        m_pending = 1'b0;
      end else begin
        m_high    = nv;
        m_pending = 1'b1;
      end
    end else if (c == 8'h0D || c == 8'h0A || c == 8'h20) begin
      m_pending = 1'b0;
    end else begin
      push_ev(EV_HEX, c);
      m_pending = 1'b0;
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    fpga_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop_bit, CPB);
    fpga_rx = 1'b1;
  endtask

  task automatic send_char(input logic [7:0] c);
    model_char(c);
    send_frame(c, 1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
    hold(1'b1, 2 * CPB);
  endtask

  // Compare process: checks every output on every falling edge.
  initial begin
    logic [7:0] v;
    int         np;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        exp_data = '0;
        prev_cv  = 1'b0;
        chk("rst_rx_char", rx_char, 8'h00);
        chk("rst_data", data, 8'h00);
        chk("rst_pulses", {4'b0, char_valid, data_valid, frame_err, hex_err}, 8'h00);
      end else begin
        np = int'(char_valid) + int'(data_valid) + int'(frame_err) + int'(hex_err);
        chk("pulse_overlap", 8'(np > 1), 8'h00);
        if (char_valid) take("char_valid", EV_CHAR, rx_char, v);
        if (frame_err)  take("frame_err", EV_FRM, 8'h00, v);
        if (hex_err) begin
          take("hex_err", EV_HEX, rx_char, v);
          chk("hex_err_latency", 8'(prev_cv), 8'h01);
        end
        if (data_valid) begin
          take("data_valid", EV_DATA, data, v);
          chk("data_valid_latency", 8'(prev_cv), 8'h01);
          exp_data = v;
        end
        chk("data_hold", data, exp_data);
        prev_cv = char_valid;
      end
    end
  end

  initial begin
    logic [7:0] c;
    string      pool;
    pool = "0123456789abcdefABCDEF \r\nGz!~";

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);

    // Two digits -> one byte
    send_str("A5");
    chk("lit_A5", data, 8'hA5);

    // LF between bytes, trailing digit left pending
    send_str("3f\n7");
    chk("lit_3F", data, 8'h3F);

    // Space discards the dangling high nibble
    send_str("\n4 2");
    chk("lit_3F_kept", data, 8'h3F);
    send_str(" 42");
    chk("lit_42", data, 8'h42);

    // Non-hex character between digits
    send_str("1G12");
    chk("lit_12", data, 8'h12);

    // Stop bit low followed by a long break: one frame_err only
    push_ev(EV_FRM, 8'h00);
    send_frame(8'h00, 1'b0);
    hold(1'b0, 40 * CPB);
    hold(1'b1, 2 * CPB);
    send_str("FF");
    chk("lit_FF", data, 8'hFF);

    // Short low glitch on an idle line
    hold(1'b0, 5);
    hold(1'b1, 2 * CPB);

    // Reset in the middle of the second digit's data bits
    send_char("9");
    hold(1'b1, CPB);
    hold(1'b0, CPB);             // start bit of 'C' (0x43)
    hold(1'b1, CPB);
    hold(1'b1, CPB);
    hold(1'b0, CPB / 2);
    rst = 1'b1;
    m_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hold(1'b1, 2 * CPB);
    chk("lit_rst_data", data, 8'h00);
    send_str("9C");
    chk("lit_9C", data, 8'h9C);

    // Random traffic: mostly pool characters, some arbitrary bytes,
    // occasional framing errors, idle gaps down to back-to-back frames.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(99) < 20) c = 8'($urandom_range(255));
      else c = pool[$urandom_range(pool.len() - 1)];
      if ($urandom_range(99) < 6) begin
        push_ev(EV_FRM, 8'h00);
        send_frame(c, 1'b0);
        hold(1'b1, CPB + $urandom_range(CPB));
      end else begin
        send_char(c);
        if ($urandom_range(1) == 1) hold(1'b1, $urandom_range(2 * CPB));
      end
    end

    hold(1'b1, 4 * CPB);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding events, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
